// File: rtl/adder_byte_sequencer_pkg.sv
// Shared types and helpers for the byte-serial adder sequencer.
package adder_byte_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic int calc_nbytes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/adder_byte_sequencer.sv
// Feeds an external 8-bit registered adder one byte per step, LSB first, chaining carries.
// Optional: ADDER_BYTE_SEQUENCER_OVERFLOW_EN adds the out_overflow port (signed overflow).
module adder_byte_sequencer
    import adder_byte_sequencer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic [7:0]       add_x,
    output logic [7:0]       add_y,
    output logic             add_carry_in,
    input  logic [7:0]       add_sum,
    input  logic             add_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
    ,
    output logic             out_overflow
`endif
);

    localparam int NBYTES = calc_nbytes(WIDTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(ADD_LATENCY + 1);
    localparam int MSB    = WIDTH - 1;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;
    logic [7:0]       add_x_q, add_x_d;
    logic [7:0]       add_y_q, add_y_d;
    logic             add_cin_q, add_cin_d;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
    logic             overflow_q, overflow_d;
`endif

    logic [IDX_W-1:0] next_idx;
    int unsigned      cur_lo;
    int unsigned      nxt_lo;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        byte_idx_d  = byte_idx_q;
        wait_cnt_d  = wait_cnt_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        add_cin_d   = add_cin_q;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
        overflow_d  = overflow_q;
`endif
        next_idx    = byte_idx_q + 1'b1;
        cur_lo      = 32'(byte_idx_q) * BYTE_W;
        nxt_lo      = 32'(next_idx) * BYTE_W;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    carry_d    = in_carry;
                    byte_idx_d = '0;
                    // Byte 0 is presented on the accept edge so it is stable for the whole ISSUE cycle.
                    add_x_d    = in_a[7:0];
                    add_y_d    = in_b[7:0];
                    add_cin_d  = in_carry;
                    in_ready_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = CNT_W'(ADD_LATENCY);
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == CNT_W'(1)) begin
                    res_d[cur_lo +: BYTE_W] = add_sum;
                    carry_d = add_carry_out;
                    if (byte_idx_q == IDX_W'(NBYTES - 1)) begin
                        out_sum_d   = res_d;
                        out_carry_d = add_carry_out;
                        out_valid_d = 1'b1;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
                        overflow_d  = (a_q[MSB] == b_q[MSB]) && (add_sum[7] != a_q[MSB]);
`endif
                        state_d     = DONE;
                    end else begin
                        byte_idx_d = next_idx;
                        add_x_d    = a_q[nxt_lo +: BYTE_W];
                        add_y_d    = b_q[nxt_lo +: BYTE_W];
                        add_cin_d  = add_carry_out;
                        state_d    = ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    add_x_d     = '0;
                    add_y_d     = '0;
                    add_cin_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            byte_idx_q  <= '0;
            wait_cnt_q  <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            add_cin_q   <= 1'b0;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            byte_idx_q  <= byte_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            add_cin_q   <= add_cin_d;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_carry    = out_carry_q;
    assign add_x        = add_x_q;
    assign add_y        = add_y_q;
    assign add_carry_in = add_cin_q;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
    assign out_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Directed bench for adder_byte_sequencer with a 2-cycle behavioural byte adder.
module tb_adder_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_carry;
    logic [7:0]  add_x;
    logic [7:0]  add_y;
    logic        add_carry_in;
    logic [7:0]  add_sum;
    logic        add_carry_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
    logic        out_overflow;
`endif

    int total = 0;
    int bad   = 0;

    adder_byte_sequencer #(.WIDTH(32), .ADD_LATENCY(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_carry     (in_carry),
        .add_x        (add_x),
        .add_y        (add_y),
        .add_carry_in (add_carry_in),
        .add_sum      (add_sum),
        .add_carry_out(add_carry_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry)
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
        ,
        .out_overflow (out_overflow)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural two-stage byte adder
    logic [8:0] stage1 = '0;
    logic [8:0] stage2 = '0;
    always @(posedge clk) begin
        stage1 <= 9'(add_x) + 9'(add_y) + 9'(add_carry_in);
        stage2 <= stage1;
    end
    assign add_sum       = stage2[7:0];
    assign add_carry_out = stage2[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_carry"}, out_carry, 0);
        check({tag, "_add_x"}, add_x, 0);
        check({tag, "_add_y"}, add_y, 0);
        check({tag, "_add_cin"}, add_carry_in, 0);
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
        check({tag, "_out_overflow"}, out_overflow, 0);
`endif
    endtask

    // driver: one full transaction, checking byte issue, latency, result and handshake
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [31:0] exp_sum, input logic exp_c,
                           input logic exp_ovf, input int hold);
        int          k;
        int          j;
        logic [63:0] mask;
        logic [63:0] part;
        logic [7:0]  exp_byte;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (k == 1) check({tag, "_in_ready_busy"}, in_ready, 0);
            if (k <= 12) begin
                j        = (k - 1) / 3;
                exp_byte = 8'(a >> (8 * j));
                check({tag, "_add_x"}, add_x, exp_byte);
                exp_byte = 8'(b >> (8 * j));
                check({tag, "_add_y"}, add_y, exp_byte);
                if ((k % 3) == 1) begin
                    mask = (64'd1 << (8 * j)) - 64'd1;
                    part = ({32'd0, a} & mask) + ({32'd0, b} & mask) + 64'(cin);
                    check({tag, "_add_cin"}, add_carry_in, (part >> (8 * j)) & 64'd1);
                end
            end
        end
        check({tag, "_latency"}, k, 13);
        if (!out_valid) return;
        check({tag, "_out_sum"}, out_sum, exp_sum);
        check({tag, "_out_carry"}, out_carry, exp_c);
`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
        check({tag, "_out_overflow"}, out_overflow, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note: overflow expectation undefined for %s", tag);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_sum"}, out_sum, exp_sum);
            check({tag, "_hold_carry"}, out_carry, exp_c);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_in_ready"}, in_ready, 1);
        check({tag, "_post_out_valid"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset_values("reset");
        rst_n = 1'b1;

        run_txn("t1", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0);
        run_txn("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
        run_txn("t3", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
        run_txn("t4", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 5);

        // reset pulse while byte 2 is in flight
        @(negedge clk);
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h01020304;
        in_carry = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("t5", 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 0);

`ifdef ADDER_BYTE_SEQUENCER_OVERFLOW_EN
        run_txn("ov1", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
        run_txn("ov2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
